// File: rtl/if_stage_ibuf.sv
// Instruction fetch stage: credit-limited SRAM request issue, in-order tag FIFO,
// and an instruction buffer feeding ID, with flush/redirect discard accounting.
module if_stage_ibuf #(
  parameter logic [31:0] RESET_PC   = 32'h1C000000,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUTSTD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic        wb_ex,
  input  logic [31:0] csr_eentry,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int TW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam int CW = $clog2(IBUF_DEPTH + MAX_OUTSTD + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTD);
  localparam logic [TW-1:0] TLAST   = TW'(MAX_OUTSTD - 1);

  logic [31:0]   fetch_pc;
  logic          req_hold;
  logic          redir_pend;
  logic [31:0]   redir_tgt;
  logic          halt;
  logic [CW-1:0] outstd;
  logic [CW-1:0] discard_cnt;

  logic [31:0]   tag_mem [MAX_OUTSTD];
  logic [TW-1:0] tag_wr, tag_rd, tag_wr_nxt, tag_rd_nxt;

  logic [64:0]   ibuf_mem [IBUF_DEPTH];
  logic [AW-1:0] ib_wr, ib_rd;
  logic [CW-1:0] ib_cnt;

  logic          redir;
  logic [31:0]   redir_target;
  logic          aligned;
  logic          can_issue;
  logic          accept;
  logic          dok;
  logic          drop;
  logic          data_push;
  logic          adef_push;
  logic          ib_push;
  logic          ib_pop;
  logic [64:0]   ib_wdata;
  logic [CW-1:0] outstd_nxt;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc;

  always_comb begin
    redir        = wb_ex | ertn_flush | br_bus[32];
    redir_target = br_bus[31:0];
    if (wb_ex)
      redir_target = csr_eentry;
    else if (ertn_flush)
      redir_target = csr_era;
  end

  assign aligned   = (fetch_pc[1:0] == 2'b00);
  // Credit rule: every accepted request already owns a buffer slot.
  assign can_issue = !req_hold && !halt && aligned && (outstd < MAXO_C)
                     && ((outstd + ib_cnt) < DEPTH_C);
  assign inst_sram_req = !reset && (req_hold || can_issue);
  assign accept        = inst_sram_req && inst_sram_addr_ok;

  assign dok        = !reset && inst_sram_data_ok && (outstd != '0);
  assign drop       = dok && (redir || (discard_cnt != '0));
  assign data_push  = dok && !drop;
  assign adef_push  = !reset && !redir && !aligned && !halt && !req_hold && !redir_pend
                      && (outstd == '0) && (discard_cnt == '0) && (ib_cnt != DEPTH_C);
  assign ib_push    = data_push || adef_push;
  assign ib_pop     = fs_to_ds_valid && ds_allowin;
  assign ib_wdata   = adef_push ? {1'b1, 32'h0, fetch_pc}
                                : {1'b0, inst_sram_rdata, tag_mem[tag_rd]};
  assign outstd_nxt = outstd + CW'(accept) - CW'(dok);

  assign tag_wr_nxt = (tag_wr == TLAST) ? '0 : tag_wr + TW'(1);
  assign tag_rd_nxt = (tag_rd == TLAST) ? '0 : tag_rd + TW'(1);

  assign fs_to_ds_valid = !reset && (ib_cnt != '0);
  assign fs_to_ds_bus   = ibuf_mem[ib_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_hold    <= 1'b0;
      redir_pend  <= 1'b0;
      redir_tgt   <= '0;
      halt        <= 1'b0;
      outstd      <= '0;
      discard_cnt <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      ib_wr       <= '0;
      ib_rd       <= '0;
      ib_cnt      <= '0;
    end else begin
      req_hold <= inst_sram_req && !inst_sram_addr_ok;
      outstd   <= outstd_nxt;
      if (accept) tag_wr <= tag_wr_nxt;
      if (dok)    tag_rd <= tag_rd_nxt;
      if (redir) begin
        halt        <= 1'b0;
        discard_cnt <= outstd_nxt;
        ib_wr       <= '0;
        ib_rd       <= '0;
        ib_cnt      <= '0;
        // A still-pending request must keep its address; apply the target after it goes.
        if (inst_sram_req && !inst_sram_addr_ok) begin
          redir_pend <= 1'b1;
          redir_tgt  <= redir_target;
        end else begin
          redir_pend <= 1'b0;
          fetch_pc   <= redir_target;
        end
      end else begin
        if (accept) begin
          fetch_pc   <= redir_pend ? redir_tgt : fetch_pc + 32'd4;
          redir_pend <= 1'b0;
        end
        discard_cnt <= discard_cnt + CW'(accept && redir_pend)
                       - CW'(dok && (discard_cnt != '0));
        if (adef_push) halt <= 1'b1;
        if (ib_push)   ib_wr <= ib_wr + AW'(1);
        if (ib_pop)    ib_rd <= ib_rd + AW'(1);
        ib_cnt <= ib_cnt + CW'(ib_push) - CW'(ib_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)              tag_mem[tag_wr] <= fetch_pc;
    if (!reset && ib_push)   ibuf_mem[ib_wr] <= ib_wdata;
  end

endmodule
